decode_pipe: RTL and testbench



---
 rtl/decode_pipe.sv | 130 +++++++++++++
 tb/tb_decode_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// decode_pipe: RV32I decode stage with register file, write-back bypass, load-use interlock and ID/EX register
module decode_pipe #(
    parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
    parameter bit          BYPASS_WB      = 1'b1,
    parameter bit          LOAD_USE_STALL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    input  logic        i_wb_wen,
    input  logic [4:0]  i_wb_waddr,
    input  logic [31:0] i_wb_wdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic [4:0]  o_rs1_raddr,
    output logic [4:0]  o_rs2_raddr,
    output logic [4:0]  o_rd,
    output logic [31:0] o_rs1_rdata,
    output logic [31:0] o_rs2_rdata,
    output logic [31:0] o_immediate,
    output logic [5:0]  o_format,
    output logic [2:0]  o_funct3,
    output logic [6:0]  o_funct7,
    output logic        o_reg_write,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_illegal
);
    logic [31:0] regs [32];
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  fmt;
    logic [31:0] imm, rs1_val, rs2_val;
    logic        use1, use2, held_use1, held_use2, hazard, accept, wb_live;

    assign op  = i_instr[6:0];
    assign rs1 = i_instr[19:15];
    assign rs2 = i_instr[24:20];
    assign rd  = i_instr[11:7];
    assign wb_live = i_wb_wen && i_wb_waddr != 5'd0;

    // Format, immediate, operand read with optional bypass, and handshake/hazard logic
    always_comb begin
        fmt = (op == 7'b0110011) ? 6'b000001 :
              (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) ? 6'b000010 :
              (op == 7'b0100011) ? 6'b000100 :
              (op == 7'b1100011) ? 6'b001000 :
              (op == 7'b0110111 || op == 7'b0010111) ? 6'b010000 :
              (op == 7'b1101111) ? 6'b100000 : 6'b000000;
        imm = fmt[1] ? {{20{i_instr[31]}}, i_instr[31:20]} :
              fmt[2] ? {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]} :
              fmt[3] ? {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
              fmt[4] ? {i_instr[31:12], 12'b0} :
              fmt[5] ? {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
              32'b0;
        use1 = |fmt[3:0];
        use2 = fmt[0] || fmt[2] || fmt[3];
        held_use1 = |o_format[3:0];
        held_use2 = o_format[0] || o_format[2] || o_format[3];
        rs1_val = (rs1 == 5'd0) ? 32'b0 :
                  (BYPASS_WB && wb_live && i_wb_waddr == rs1) ? i_wb_wdata : regs[rs1];
        rs2_val = (rs2 == 5'd0) ? 32'b0 :
                  (BYPASS_WB && wb_live && i_wb_waddr == rs2) ? i_wb_wdata : regs[rs2];
        hazard = LOAD_USE_STALL && o_valid && o_mem_read && o_rd != 5'd0 &&
                 ((use1 && rs1 == o_rd) || (use2 && rs2 == o_rd));
        o_ready = !i_rst && !i_flush && !hazard && (!o_valid || i_ready);
        accept = i_valid && o_ready;
    end

    // Register file; x0 is never written so it stays zero after reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 32; k++) regs[k] <= 32'b0;
        end else if (wb_live) begin
            regs[i_wb_waddr] <= i_wb_wdata;
        end
    end

    // ID/EX register: flush beats accept, accept beats drain, a held entry picks up late write-backs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_pc        <= RESET_ADDR;
            o_instr     <= 32'b0;
            o_rs1_raddr <= 5'b0;
            o_rs2_raddr <= 5'b0;
            o_rd        <= 5'b0;
            o_rs1_rdata <= 32'b0;
            o_rs2_rdata <= 32'b0;
            o_immediate <= 32'b0;
            o_format    <= 6'b0;
            o_funct3    <= 3'b0;
            o_funct7    <= 7'b0;
            o_reg_write <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_illegal   <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (accept) begin
            o_valid     <= 1'b1;
            o_pc        <= i_pc;
            o_instr     <= i_instr;
            o_rs1_raddr <= rs1;
            o_rs2_raddr <= rs2;
            o_rd        <= rd;
            o_rs1_rdata <= rs1_val;
            o_rs2_rdata <= rs2_val;
            o_immediate <= imm;
            o_format    <= fmt;
            o_funct3    <= i_instr[14:12];
            o_funct7    <= i_instr[31:25];
            o_reg_write <= (fmt[0] || fmt[1] || fmt[4] || fmt[5]) && rd != 5'd0;
            o_mem_read  <= op == 7'b0000011;
            o_mem_write <= op == 7'b0100011;
            o_illegal   <= fmt == 6'b0;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end else if (o_valid) begin
            if (wb_live && i_wb_waddr == o_rs1_raddr && held_use1) o_rs1_rdata <= i_wb_wdata;
            if (wb_live && i_wb_waddr == o_rs2_raddr && held_use2) o_rs2_rdata <= i_wb_wdata;
        end
    end
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed vector table plus hand-written multi-cycle sequences for decode_pipe
module tb_decode_pipe;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0, i_wb_wen = 1'b0;
    logic [31:0] i_instr = 32'b0, i_pc = 32'b0, i_wb_wdata = 32'b0;
    logic [4:0]  i_wb_waddr = 5'b0;
    logic        o_ready, o_valid, o_reg_write, o_mem_read, o_mem_write, o_illegal;
    logic [31:0] o_pc, o_instr, o_rs1_rdata, o_rs2_rdata, o_immediate;
    logic [4:0]  o_rs1_raddr, o_rs2_raddr, o_rd;
    logic [5:0]  o_format;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    int errors = 0, checks = 0;

    decode_pipe #(.RESET_ADDR(RST_PC), .BYPASS_WB(1'b1), .LOAD_USE_STALL(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush),
        .i_wb_wen(i_wb_wen), .i_wb_waddr(i_wb_waddr), .i_wb_wdata(i_wb_wdata),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_instr(o_instr),
        .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr), .o_rd(o_rd),
        .o_rs1_rdata(o_rs1_rdata), .o_rs2_rdata(o_rs2_rdata), .o_immediate(o_immediate),
        .o_format(o_format), .o_funct3(o_funct3), .o_funct7(o_funct7),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [5:0]  fmt;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ua;
        logic        ub;
        logic [31:0] a;
        logic [31:0] b;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
    } vec_t;

    vec_t tv [12];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        i_valid = 1'b1;
        i_instr = ins;
        i_pc    = pc;
    endtask

    task automatic wb_set(input logic [4:0] a, input logic [31:0] d);
        i_wb_wen   = 1'b1;
        i_wb_waddr = a;
        i_wb_wdata = d;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_set(a, d);
        tick();
        i_wb_wen = 1'b0;
    endtask

    initial begin
        tv[0]  = '{32'h00528333, 6'b000001, 32'h0,        5'd6,  1'b1, 1'b1, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{32'hFFF08393, 6'b000010, 32'hFFFFFFFF, 5'd7,  1'b1, 1'b0, 32'h100,      32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{32'hFE20AE23, 6'b000100, 32'hFFFFFFFC, 5'd28, 1'b1, 1'b1, 32'h100,      32'h22,       1'b0, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{32'hFE208CE3, 6'b001000, 32'hFFFFFFF8, 5'd25, 1'b1, 1'b1, 32'h100,      32'h22,       1'b0, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{32'h000000E3, 6'b001000, 32'h00000800, 5'd1,  1'b1, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{32'h00410183, 6'b000010, 32'h00000004, 5'd3,  1'b1, 1'b0, 32'h22,       32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        tv[6]  = '{32'hABCDE537, 6'b010000, 32'hABCDE000, 5'd10, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{32'h00001017, 6'b010000, 32'h00001000, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{32'hFFFFF0EF, 6'b100000, 32'hFFFFFFFE, 5'd1,  1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{32'h003002EF, 6'b100000, 32'h00000802, 5'd5,  1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
        tv[10] = '{32'h00000073, 6'b000000, 32'h0,        5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1};
        tv[11] = '{32'h0000000F, 6'b000000, 32'h0,        5'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1};

        tick();
        tick();
        chk("rst_ready", 32'(o_ready), 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_pc", o_pc, RST_PC);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_format", 32'(o_format), 32'h0);
        rst = 1'b0;
        i_ready = 1'b1;
        wb_write(5'd1, 32'h100);
        wb_write(5'd2, 32'h22);
        wb_write(5'd5, 32'h12345678);
        wb_write(5'd8, 32'h88);

        for (int i = 0; i < 12; i++) begin
            issue(tv[i].instr, 32'h1000 + 32'(i) * 4);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(o_ready), 32'h1);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'h1);
            chk($sformatf("v%0d_pc", i), o_pc, 32'h1000 + 32'(i) * 4);
            chk($sformatf("v%0d_format", i), 32'(o_format), 32'(tv[i].fmt));
            chk($sformatf("v%0d_imm", i), o_immediate, tv[i].imm);
            chk($sformatf("v%0d_rd", i), 32'(o_rd), 32'(tv[i].rd));
            chk($sformatf("v%0d_reg_write", i), 32'(o_reg_write), 32'(tv[i].rw));
            chk($sformatf("v%0d_mem_read", i), 32'(o_mem_read), 32'(tv[i].mr));
            chk($sformatf("v%0d_mem_write", i), 32'(o_mem_write), 32'(tv[i].mw));
            chk($sformatf("v%0d_illegal", i), 32'(o_illegal), 32'(tv[i].ill));
            if (tv[i].ua) chk($sformatf("v%0d_rs1", i), o_rs1_rdata, tv[i].a);
            if (tv[i].ub) chk($sformatf("v%0d_rs2", i), o_rs2_rdata, tv[i].b);
        end
        i_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(o_valid), 32'h0);

        issue(32'hFFF28393, 32'h1100);
        wb_set(5'd5, 32'hA);
        tick();
        i_wb_wen = 1'b0;
        chk("bypass_rs1", o_rs1_rdata, 32'hA);
        chk("bypass_imm", o_immediate, 32'hFFFFFFFF);
        issue(32'h00528333, 32'h1104);
        tick();
        chk("rf_after_bypass_rs1", o_rs1_rdata, 32'hA);
        chk("rf_after_bypass_rs2", o_rs2_rdata, 32'hA);
        issue(32'h000005B3, 32'h1108);
        wb_set(5'd0, 32'hDEAD);
        tick();
        i_wb_wen = 1'b0;
        chk("x0_no_bypass", o_rs1_rdata, 32'h0);

        issue(32'h0000A403, 32'h1200);
        tick();
        issue(32'h002404B3, 32'h1204);
        #1;
        chk("lu_stall_ready", 32'(o_ready), 32'h0);
        tick();
        chk("lu_bubble", 32'(o_valid), 32'h0);
        chk("lu_ready_after", 32'(o_ready), 32'h1);
        wb_set(5'd8, 32'h77);
        tick();
        i_wb_wen = 1'b0;
        chk("lu_dep_valid", 32'(o_valid), 32'h1);
        chk("lu_dep_instr", o_instr, 32'h002404B3);
        chk("lu_dep_rs1", o_rs1_rdata, 32'h77);
        chk("lu_dep_rs2", o_rs2_rdata, 32'h22);
        issue(32'h0000A403, 32'h1208);
        tick();
        issue(32'h002084B3, 32'h120C);
        #1;
        chk("lu_nodep_ready", 32'(o_ready), 32'h1);
        tick();
        chk("lu_nodep_pc", o_pc, 32'h120C);
        issue(32'h0000A003, 32'h1210);
        tick();
        issue(32'h002004B3, 32'h1214);
        #1;
        chk("lu_x0_ready", 32'(o_ready), 32'h1);
        tick();
        chk("lu_x0_pc", o_pc, 32'h1214);

        issue(32'h00528333, 32'h2000);
        tick();
        i_ready = 1'b0;
        issue(32'h002084B3, 32'h2004);
        #1;
        chk("hold_ready1", 32'(o_ready), 32'h0);
        tick();
        wb_set(5'd5, 32'h99);
        tick();
        i_wb_wen = 1'b0;
        tick();
        chk("hold_valid", 32'(o_valid), 32'h1);
        chk("hold_pc", o_pc, 32'h2000);
        chk("hold_instr", o_instr, 32'h00528333);
        chk("hold_rs1", o_rs1_rdata, 32'h99);
        chk("hold_rs2", o_rs2_rdata, 32'h99);
        chk("hold_ready3", 32'(o_ready), 32'h0);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        chk("hold_release", 32'(o_valid), 32'h0);

        issue(32'h00528333, 32'h3000);
        tick();
        issue(32'h002084B3, 32'h3004);
        i_flush = 1'b1;
        wb_set(5'd12, 32'h1234);
        #1;
        chk("flush_ready", 32'(o_ready), 32'h0);
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_wb_wen = 1'b0;
        chk("flush_valid", 32'(o_valid), 32'h0);
        tick();
        chk("flush_dropped", 32'(o_valid), 32'h0);
        issue(32'h000606B3, 32'h3008);
        tick();
        chk("flush_wb_kept", o_rs1_rdata, 32'h1234);
        chk("post_flush_pc", o_pc, 32'h3008);
        issue(32'h00000073, 32'h300C);
        tick();
        chk("ecall_illegal", 32'(o_illegal), 32'h1);
        chk("ecall_format", 32'(o_format), 32'h0);
        chk("ecall_reg_write", 32'(o_reg_write), 32'h0);

        issue(32'h00528333, 32'h4000);
        tick();
        i_ready = 1'b0;
        issue(32'h002084B3, 32'h4004);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_stall_ready", 32'(o_ready), 32'h0);
        tick();
        rst = 1'b0;
        i_valid = 1'b0;
        chk("rst_stall_valid", 32'(o_valid), 32'h0);
        chk("rst_stall_pc", o_pc, RST_PC);
        chk("rst_stall_instr", o_instr, 32'h0);
        i_ready = 1'b1;
        for (int k = 1; k < 32; k++) begin
            logic [4:0] r;
            r = 5'(k);
            issue({7'b0, r, r, 3'b0, 5'b0, 7'b0110011}, 32'h5000 + 32'(k) * 4);
            tick();
            chk($sformatf("clr_x%0d_rs1", k), o_rs1_rdata, 32'h0);
            chk($sformatf("clr_x%0d_rs2", k), o_rs2_rdata, 32'h0);
        end
        i_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
